// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage sequencer: owns the PC and shares the instruction-memory port between loader and fetch
module fetch_controller #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_halt,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_STEP = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              ret_halt;
    logic              halt_cmd;
    logic [ADDR_W-1:0] pc_next;

    // valid_q marks that imem_rdata holds the result of an unsquashed fetch
    assign ret_halt = valid_q && (imem_rdata == HALT_WORD);
    assign halt_cmd = (state_q == ST_RUN) && cmd_halt;
    assign pc_next  = branch_taken ? branch_target : pc_q + ADDR_W'(1);

    assign if_valid = valid_q && !ret_halt && !halt_cmd;
    assign if_instr = imem_rdata;
    assign if_pc    = if_pc_q;
    assign halted   = halted_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_addr_d = load_addr_q;
        if_pc_d     = if_pc_q;
        valid_d     = 1'b0;
        halted_d    = halted_q;
        load_ready  = 1'b0;
        imem_en     = 1'b0;
        imem_we     = 1'b0;
        imem_addr   = '0;
        imem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                // a stepped HALT_WORD returns while already back in IDLE
                if (ret_halt) begin
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                end else if (load_start) begin
                    state_d     = ST_LOAD;
                    load_addr_d = '0;
                end else if (cmd_run) begin
                    state_d = ST_RUN;
                end else if (cmd_step) begin
                    state_d = ST_STEP;
                end
            end

            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    imem_en     = 1'b1;
                    imem_we     = 1'b1;
                    imem_addr   = load_addr_q;
                    imem_wdata  = load_data;
                    load_addr_d = (load_addr_q == ADDR_MAX) ? load_addr_q : load_addr_q + ADDR_W'(1);
                    if (load_data == HALT_WORD || load_addr_q == ADDR_MAX) begin
                        state_d = ST_IDLE;
                        pc_d    = '0;
                    end
                end
            end

            ST_RUN: begin
                if (cmd_halt) begin
                    state_d = ST_IDLE;
                end else if (ret_halt) begin
                    // the fetch issued alongside the halt word is discarded and pc stays at halt+1
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                    if (!stall) begin
                        imem_en   = 1'b1;
                        imem_addr = pc_q;
                    end
                end else if (stall) begin
                    valid_d = valid_q;
                end else begin
                    imem_en   = 1'b1;
                    imem_addr = pc_q;
                    if_pc_d   = pc_q;
                    valid_d   = !branch_taken;
                    pc_d      = pc_next;
                end
            end

            ST_STEP: begin
                if (stall) begin
                    valid_d = valid_q;
                end else begin
                    imem_en   = 1'b1;
                    imem_addr = pc_q;
                    if_pc_d   = pc_q;
                    valid_d   = !branch_taken;
                    pc_d      = pc_next;
                    state_d   = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (load_start) begin
                    state_d     = ST_LOAD;
                    halted_d    = 1'b0;
                    load_addr_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            load_addr_q <= '0;
            if_pc_q     <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            load_addr_q <= load_addr_d;
            if_pc_q     <= if_pc_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller with a behavioural memory and fetch model
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_start = 1'b0, load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0;
    logic [6:0]  branch_target = '0;
    logic        imem_en, imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata, imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [6:0]  if_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [128];
    logic [31:0] exp_mem [128];
    logic [31:0] rdata_q = '0;

    always #5 clock = ~clock;

    fetch_controller dut (
        .clock(clock), .reset_n(reset_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .halted(halted)
    );

    // single-port synchronous memory, one-cycle read latency, output holds when not read
    assign imem_rdata = rdata_q;
    always @(posedge clock) begin
        if (imem_en) begin
            if (imem_we) mem[imem_addr] <= imem_wdata;
            else         rdata_q <= mem[imem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load_words(input logic [31:0] w[$], input bit gaps);
        load_start = 1'b1;
        adv();
        chk("load_halted_clr", 32'(halted), 0);
        foreach (w[i]) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                    settle();
                    chk("load_gap_ready", 32'(load_ready), 1);
                    chk("load_gap_en", 32'(imem_en), 0);
                    adv();
                end
            end
            load_valid = 1'b1;
            load_data  = w[i];
            settle();
            chk("load_ready", 32'(load_ready), 1);
            chk("load_en_we", 32'({imem_en, imem_we}), 3);
            chk("load_addr", 32'(imem_addr), i);
            chk("load_wdata", imem_wdata, w[i]);
            adv();
            exp_mem[i] = w[i];
        end
        settle();
        chk("load_ready_drop", 32'(load_ready), 0);
        adv();
    endtask

    // reference: pc advances by rule, a fetch issued in one cycle is presented the next
    task automatic rand_run(input int plen);
        int  m_pc = 0;
        int  p_pc = 0;
        bit  p_valid = 0;
        bit  m_run = 1;
        bit  m_halted = 0;
        bit  st, br, ch, rh, exp_v, exp_en;
        int  tgt;
        cmd_run = 1'b1;
        settle();
        chk("rr_idle_en", 32'(imem_en), 0);
        adv();
        for (int c = 0; c < 400 && m_run; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 11) == 0);
            tgt = $urandom_range(0, plen - 1);
            ch  = (c == 399);
            stall = st; branch_taken = br; branch_target = tgt[6:0]; cmd_halt = ch;
            rh     = p_valid && (exp_mem[p_pc] == HALT);
            exp_v  = p_valid && !rh && !ch;
            exp_en = !st && !ch;
            settle();
            chk("rr_if_valid", 32'(if_valid), 32'(exp_v));
            if (exp_v) begin
                chk("rr_if_pc", 32'(if_pc), p_pc);
                chk("rr_if_instr", if_instr, exp_mem[p_pc]);
            end
            chk("rr_en", 32'(imem_en), 32'(exp_en));
            if (exp_en) chk("rr_addr", 32'(imem_addr), m_pc);
            adv();
            if (ch) begin
                m_run = 0; p_valid = 0;
            end else if (rh) begin
                m_run = 0; p_valid = 0; m_halted = 1;
            end else if (!st) begin
                p_valid = !br;
                p_pc    = m_pc;
                m_pc    = br ? tgt : (m_pc + 1) % 128;
            end
        end
        settle();
        chk("rr_halted", 32'(halted), 32'(m_halted));
        chk("rr_after_en", 32'(imem_en), 0);
        adv();
    endtask

    typedef struct packed {
        logic ls, run, step, hlt;
        logic ready, en1, en2;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] w[$];
        logic [31:0] r;
        int          plen;

        vecs[0] = 7'b0000_000;
        vecs[1] = 7'b0001_000;
        vecs[2] = 7'b0100_011;
        vecs[3] = 7'b0010_010;
        vecs[4] = 7'b1100_100;
        vecs[5] = 7'b1010_100;
        vecs[6] = 7'b0110_011;
        vecs[7] = 7'b0101_011;

        for (int i = 0; i < 128; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end

        @(posedge clock);
        #1;
        chk("rst_ready", 32'(load_ready), 0);
        chk("rst_en_we", 32'({imem_en, imem_we}), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_if", 32'({if_valid, if_pc}), 0);
        chk("rst_halted", 32'(halted), 0);
        reset_n = 1'b1;

        // IDLE command priority
        for (int i = 0; i < 8; i++) begin
            do_reset();
            {load_start, cmd_run, cmd_step, cmd_halt} = {vecs[i].ls, vecs[i].run, vecs[i].step, vecs[i].hlt};
            adv();
            settle();
            chk($sformatf("vec%0d_ready", i), 32'(load_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_en1", i), 32'(imem_en), 32'(vecs[i].en1));
            adv();
            settle();
            chk($sformatf("vec%0d_en2", i), 32'(imem_en), 32'(vecs[i].en2));
            adv();
        end
        do_reset();

        // three-word load then run into the halt word
        w = '{32'h2001_0005, 32'h2002_0003, HALT};
        load_words(w, 0);
        chk("ld3_mem0", mem[0], 32'h2001_0005);
        chk("ld3_mem1", mem[1], 32'h2002_0003);
        chk("ld3_mem2", mem[2], HALT);
        cmd_run = 1'b1;
        settle(); chk("run_entry_en", 32'(imem_en), 0); adv();
        settle(); chk("run_c1_en", 32'(imem_en), 1); chk("run_c1_addr", 32'(imem_addr), 0);
        chk("run_c1_valid", 32'(if_valid), 0); adv();
        settle(); chk("run_c2_valid", 32'(if_valid), 1); chk("run_c2_pc", 32'(if_pc), 0);
        chk("run_c2_instr", if_instr, 32'h2001_0005); adv();
        settle(); chk("run_c3_valid", 32'(if_valid), 1); chk("run_c3_pc", 32'(if_pc), 1);
        chk("run_c3_instr", if_instr, 32'h2002_0003); adv();
        settle(); chk("run_halt_word_valid", 32'(if_valid), 0); adv();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("done_halted", 32'(halted), 1);
            chk("done_en", 32'(imem_en), 0);
            chk("done_valid", 32'(if_valid), 0);
            adv();
        end

        // stall at pc 5, branch at pc 10, branch under stall, halt command
        w = {};
        for (int i = 0; i < 20; i++) w.push_back(32'h0100_0000 + i);
        w.push_back(HALT);
        load_words(w, 0);
        cmd_run = 1'b1;
        adv();
        for (int k = 1; k <= 20; k++) begin
            if (k >= 6 && k <= 8) stall = 1'b1;
            if (k == 14) begin branch_taken = 1'b1; branch_target = 7'h40; end
            if (k == 17) begin stall = 1'b1; branch_taken = 1'b1; branch_target = 7'd3; end
            if (k == 19) cmd_halt = 1'b1;
            settle();
            if (k <= 5) begin
                chk("seq_addr", 32'(imem_addr), k - 1);
                if (k > 1) chk("seq_pc", 32'(if_pc), k - 2);
            end else if (k <= 8) begin
                chk("stall_en", 32'(imem_en), 0);
                chk("stall_valid", 32'(if_valid), 1);
                chk("stall_pc", 32'(if_pc), 4);
                chk("stall_instr", if_instr, 32'h0100_0004);
            end else if (k <= 14) begin
                chk("resume_en", 32'(imem_en), 1);
                chk("resume_addr", 32'(imem_addr), k - 4);
                chk("resume_pc", 32'(if_pc), k - 5);
            end else if (k == 15) begin
                chk("br_squash", 32'(if_valid), 0);
                chk("br_target_addr", 32'(imem_addr), 32'h40);
            end else if (k == 16) begin
                chk("br_valid", 32'(if_valid), 1);
                chk("br_pc", 32'(if_pc), 32'h40);
                chk("br_instr", if_instr, exp_mem[64]);
            end else if (k == 17) begin
                chk("br_stall_en", 32'(imem_en), 0);
            end else if (k == 18) begin
                chk("br_ignored_addr", 32'(imem_addr), 32'h42);
                chk("br_ignored_pc", 32'(if_pc), 32'h41);
            end else if (k == 19) begin
                chk("chalt_squash", 32'(if_valid), 0);
                chk("chalt_en", 32'(imem_en), 0);
            end else begin
                chk("chalt_idle_en", 32'(imem_en), 0);
            end
            adv();
        end

        // park pc at 127, then step twice across the wrap
        cmd_run = 1'b1; adv();
        branch_taken = 1'b1; branch_target = 7'd127;
        settle(); chk("resume_at_43", 32'(imem_addr), 32'h43); adv();
        cmd_halt = 1'b1; settle(); adv();
        cmd_step = 1'b1; settle(); chk("step_idle_en", 32'(imem_en), 0); adv();
        settle(); chk("step1_en", 32'(imem_en), 1); chk("step1_addr", 32'(imem_addr), 127); adv();
        cmd_step = 1'b1;
        settle(); chk("step1_valid", 32'(if_valid), 1); chk("step1_pc", 32'(if_pc), 127);
        chk("step1_idle_en", 32'(imem_en), 0); adv();
        settle(); chk("step2_en", 32'(imem_en), 1); chk("step2_addr", 32'(imem_addr), 0); adv();
        settle(); chk("step2_valid", 32'(if_valid), 1); chk("step2_pc", 32'(if_pc), 0);
        chk("step2_instr", if_instr, 32'h0100_0000); chk("step2_idle_en", 32'(imem_en), 0); adv();
        settle(); chk("step_done_valid", 32'(if_valid), 0); adv();

        // full 128-word load exits at the last address
        w = {};
        for (int i = 0; i < 128; i++) begin
            r = $urandom();
            if (r == HALT) r = '0;
            w.push_back(r);
        end
        load_words(w, 1);
        chk("ld128_mem127", mem[127], w[127]);

        // asynchronous reset in the middle of a load
        load_start = 1'b1; adv();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = 32'hA000_0000 + i;
            adv();
            exp_mem[i] = 32'hA000_0000 + i;
        end
        load_valid = 1'b1; load_data = 32'hDEAD_0004;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(load_ready), 0);
        chk("arst_en_we", 32'({imem_en, imem_we}), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_if", 32'({if_valid, if_pc, halted}), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        load_valid = 1'b0; load_data = '0;
        chk("arst_mem3", mem[3], 32'hA000_0003);
        chk("arst_mem4_kept", mem[4], exp_mem[4]);
        w = '{32'h1111_2222, HALT};
        load_words(w, 0);

        // randomized programs with random stalls and branches
        for (int it = 0; it < 4; it++) begin
            plen = $urandom_range(8, 60);
            w = {};
            for (int i = 0; i < plen - 1; i++) begin
                r = $urandom();
                if (r == HALT) r = '0;
                w.push_back(r);
            end
            w.push_back(HALT);
            load_words(w, 1);
            rand_run(plen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end of test expected finish within 50000 cycles");
        $fatal(1, "timeout");
    end

endmodule
